// File: rtl/stream_pkg.sv
// stream_pkg: shared state encoding and word type for the running-sum stream controller
package stream_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int STREAM_W = 32;
  typedef logic [STREAM_W-1:0] word_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-request round-robin arbiter, one-hot grant
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);
  assign gnt[0] = en && req[0] && (!req[1] || last_grant);
  assign gnt[1] = en && req[1] && (!req[0] || !last_grant);
endmodule

// File: rtl/stream_sum_ctrl.sv
// stream_sum_ctrl: fixed-length burst accumulator fed by two round-robin arbitrated streams
module stream_sum_ctrl
  import stream_pkg::*;
#(
  parameter int WIDTH     = STREAM_W,
  parameter int BURST_LEN = 6,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             first_valid,
  input  logic [WIDTH-1:0] first_stream,
  output logic             first_ready,
  input  logic             second_valid,
  input  logic [WIDTH-1:0] second_stream,
  output logic             second_ready,
  output logic [WIDTH-1:0] running_sum,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  state_t           state, state_n;
  logic [CNT_W-1:0] count;
  logic             last_grant;
  logic [1:0]       gnt;
  logic [WIDTH:0]   sum_n;
  logic [WIDTH-1:0] data;
  logic             accept, last;
  // ready is suppressed during clear/rst so no transfer lands on an abort edge
  rr_arb2 u_arb (
    .req       ({second_valid, first_valid}),
    .last_grant(last_grant),
    .en        (state == ACCUM && !clear && !rst),
    .gnt       (gnt)
  );
  assign first_ready  = gnt[0];
  assign second_ready = gnt[1];
  assign accept       = |gnt;
  assign data         = gnt[1] ? second_stream : first_stream;
  assign sum_n        = {1'b0, running_sum} + {1'b0, data};
  assign last         = count == CNT_W'(BURST_LEN - 1);
  assign busy         = state == ACCUM;
  assign done         = state == DONE;
  always_comb begin
    state_n = clear ? IDLE :
              state == IDLE  ? (start ? ACCUM : IDLE) :
              state == ACCUM ? (accept && last ? DONE : ACCUM) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      running_sum <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      state <= state_n;
      if (clear || (state == IDLE && start)) begin
        running_sum <= '0;
        count       <= '0;
        overflow    <= 1'b0;
      end else if (accept) begin
        running_sum <= sum_n[WIDTH-1:0];
        overflow    <= overflow | sum_n[WIDTH];
        count       <= count + 1'b1;
        last_grant  <= gnt[1];
      end
    end
  end
endmodule

// File: tb/tb_stream_sum_ctrl.sv
// tb_stream_sum_ctrl: scoreboard bench with a transaction-level model of the burst accumulator
module tb_stream_sum_ctrl;
  localparam int BL = 6;
  logic        clk = 0, rst = 1, start = 0, clear = 0;
  logic        first_valid = 0, second_valid = 0;
  logic [31:0] first_stream = 0, second_stream = 0;
  logic        first_ready, second_ready, busy, done, overflow;
  logic [31:0] running_sum;

  stream_sum_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .first_valid(first_valid), .first_stream(first_stream), .first_ready(first_ready),
    .second_valid(second_valid), .second_stream(second_stream), .second_ready(second_ready),
    .running_sum(running_sum), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  rdy;
    logic [31:0] sum;
    logic        ovf;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t            exp_q[$];
  logic [32:0]     done_q[$];
  int unsigned     q0[$], q1[$];
  int              total = 0, bad = 0;
  bit              m_active = 0, m_done = 0, m_ovf = 0;
  int              m_last = 1, m_n = 0;
  longint unsigned m_sum = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ready", {62'd0, second_ready, first_ready}, {62'd0, e.rdy});
      chk("running_sum", {32'd0, running_sum}, {32'd0, e.sum});
      chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
      chk("busy", {63'd0, busy}, {63'd0, e.busy});
      chk("done", {63'd0, done}, {63'd0, e.done});
    end
  end

  always @(negedge clk) begin
    logic [32:0] r;
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else begin
        r = done_q.pop_front();
        chk("burst_result", {31'd0, overflow, running_sum}, {31'd0, r});
      end
    end
  end

  // One clock of stimulus: the model decides what the spec says should happen this cycle
  task automatic tick(input logic r, input logic c, input logic s, input logic e0, input logic e1);
    int g;
    obs_t o;
    longint unsigned d;
    @(posedge clk);
    #1;
    rst = r; clear = c; start = s;
    first_valid   = e0 && q0.size() > 0;
    second_valid  = e1 && q1.size() > 0;
    first_stream  = q0.size() > 0 ? q0[0] : $urandom;
    second_stream = q1.size() > 0 ? q1[0] : $urandom;
    g = -1;
    if (!r && !c && m_active) begin
      if (first_valid && second_valid) g = 1 - m_last;
      else if (first_valid) g = 0;
      else if (second_valid) g = 1;
    end
    o.rdy = {g == 1, g == 0}; o.sum = m_sum[31:0]; o.ovf = m_ovf; o.busy = m_active; o.done = m_done;
    exp_q.push_back(o);
    if (r) begin
      m_active = 0; m_done = 0; m_sum = 0; m_ovf = 0; m_n = 0; m_last = 1;
    end else if (c) begin
      m_active = 0; m_done = 0; m_sum = 0; m_ovf = 0; m_n = 0;
    end else if (m_done) m_done = 0;
    else if (!m_active) begin
      if (s) begin m_active = 1; m_sum = 0; m_ovf = 0; m_n = 0; end
    end else if (g >= 0) begin
      d = (g == 0) ? longint'(q0.pop_front()) : longint'(q1.pop_front());
      m_sum = m_sum + d;
      if (m_sum > 64'hFFFF_FFFF) m_ovf = 1;
      m_sum = m_sum & 64'hFFFF_FFFF;
      m_n++;
      m_last = g;
      if (m_n == BL) begin
        m_active = 0; m_done = 1;
        done_q.push_back({m_ovf, m_sum[31:0]});
      end
    end
  endtask

  task automatic flush();
    q0.delete(); q1.delete();
  endtask

  initial begin
    q0 = '{5, 6}; q1 = '{7, 8};
    tick(1, 1, 1, 1, 1);
    tick(1, 1, 1, 1, 1);
    @(negedge clk);
    chk("reset_sum", {32'd0, running_sum}, 64'd0);
    chk("reset_ready", {62'd0, second_ready, first_ready}, 64'd0);
    flush();
    q0 = '{1, 3, 5}; q1 = '{2, 4, 9};
    tick(0, 0, 1, 0, 0);
    repeat (6) tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alt_sum", {32'd0, running_sum}, 64'd24);
    chk("alt_idle", {62'd0, busy, done}, 64'd0);
    flush();
    repeat (6) q1.push_back(7);
    tick(0, 0, 1, 0, 0);
    repeat (7) tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_sum", {32'd0, running_sum}, 64'd42);
    flush();
    q0 = '{32'hFFFF_FFFF, 2}; q1 = '{0, 0, 0, 0};
    tick(0, 0, 1, 0, 0);
    repeat (7) tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_sum", {32'd0, running_sum}, 64'd1);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_cleared", {63'd0, overflow}, 64'd0);
    tick(0, 1, 0, 0, 0);
    flush();
    q0 = '{10, 20, 30, 40}; q1 = '{11, 21, 31, 41};
    tick(0, 0, 1, 0, 0);
    repeat (2) tick(0, 0, 0, 1, 1);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 0, 1, 1);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort_sum", {32'd0, running_sum}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    tick(0, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("start_clear_idle", {63'd0, busy}, 64'd0);
    flush();
    q0 = '{1, 2, 3, 4}; q1 = '{5, 6, 7, 8};
    tick(0, 0, 1, 0, 0);
    repeat (3) tick(0, 0, 1, 1, 1);
    tick(1, 1, 1, 1, 1);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_mid_sum", {32'd0, running_sum}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    flush();
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0) q0.push_back($urandom_range(0, 3) == 0 ? 32'hFFFF_0000 | $urandom_range(0, 65535) : $urandom);
      if (q1.size() == 0) q1.push_back($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom);
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_sum_ctrl.md
Name: stream_sum_ctrl

Overview:
- Burst controller and 2-way arbiter for the 32-bit running-sum stream datapath.
- Two producer streams share one accumulator through valid/ready handshakes, with round-robin grant and at most one sample accepted per cycle.
- The block sequences a fixed-length burst: start, accumulate BURST_LEN samples, pulse done, return to idle.
- Sits between the stream sources and downstream consumers of running_sum.

Parameters:
WIDTH, 32, data and accumulator width
BURST_LEN, 6, samples accepted per burst (legal range 1..2**CNT_W-1)
CNT_W, 8, burst counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle burst start request
clear  input  1  synchronous abort: return to idle, zero accumulator
first_valid  input  1  stream 0 sample valid
first_stream  input  WIDTH  stream 0 sample data
first_ready  output  1  stream 0 accepted when valid&&ready at clk edge
second_valid  input  1  stream 1 sample valid
second_stream  input  WIDTH  stream 1 sample data
second_ready  output  1  stream 1 accepted when valid&&ready at clk edge
running_sum  output  WIDTH  registered accumulator
busy  output  1  high in ACCUM
done  output  1  one-cycle pulse, burst complete
overflow  output  1  sticky carry-out flag for current burst

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Reset is sampled only on the rising clk edge.
- Reset values: state IDLE, running_sum 0, count 0, overflow 0, done 0, busy 0, last_grant=1 (stream 0 wins first tie).
- Input priority: rst > clear > start > data.
- FSM states and transitions:
  - IDLE -> ACCUM on start. The same edge zeroes running_sum, count and overflow.
  - ACCUM -> DONE on the edge accepting sample number BURST_LEN.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
  - start is ignored in ACCUM and DONE.
- Outputs per state:
  - IDLE: both ready=0, running_sum holds the last burst result.
  - DONE: both ready=0, running_sum holds.
  - ACCUM: busy=1.
- Grant, combinational, ACCUM only:
  - Both valid: grant the stream other than last_grant.
  - One valid: grant that stream.
  - None valid: no grant.
  - ready=1 only on the granted stream. ready never depends on its own valid beyond this rule.
  - last_grant updates only on an accepted transfer. Idle cycles leave the pointer and count unchanged.
- Accept, at clk edge with valid&&ready:
  - running_sum <= running_sum + data, modulo 2**WIDTH.
  - overflow <= overflow | carry-out.
  - count <= count+1.
  - Sum is visible 1 cycle after the accept edge.
- clear in any state: next cycle IDLE, running_sum 0, count 0, overflow 0, done 0. No transfer is accepted on the clear edge, because ready is forced 0 while clear=1.
- start and clear in the same cycle: clear wins, stays IDLE.
- rst mid-burst: same as reset values; any in-flight handshake is dropped.
- BURST_LEN=1: ACCUM lasts until the first accept, then DONE.

Decomposition:
- Package stream_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, ACCUM, DONE}
  - localparam STREAM_W=32
  - typedef logic [STREAM_W-1:0] word_t
- Sub-module rr_arb2: 2-request round-robin arbiter. Inputs are req[1:0], last_grant and en; outputs are a one-hot gnt[1:0]. Purely combinational.
- The pointer register stays in stream_sum_ctrl.

Test Plan:
1. Reset: rst=1 for 2 cycles, all inputs active -> running_sum=0, both ready=0, busy=0, done=0, overflow=0.
2. Alternating: start, both valid continuously, stream 0 offers 1,3,5 and stream 1 offers 2,4,9 -> grants 0,1,0,1,0,1 on 6 consecutive edges; done pulses 1 cycle; running_sum=24, then holds in IDLE.
3. Single stream: only second_valid=1 with data 7 -> 6 accepts in 6 cycles, first_ready stays 0, running_sum=42, done after the 6th accept.
4. Overflow: stream 0 sends 0xFFFFFFFF then 2, stream 1 sends 0 x4 -> running_sum=1, overflow=1 through DONE and IDLE; next start clears overflow to 0.
5. Bubbles and abort: valid low for 3 cycles mid-burst -> count and pointer unchanged. After 3 accepts assert clear -> IDLE next cycle, running_sum=0, ready=0, no done.
6. Simultaneous events: start with clear -> stays IDLE. start during ACCUM -> ignored, sum continues. rst mid-burst -> reset values.
